instruction_fetch_queue: RTL and testbench

//  Parametrised fetch unit: drives a PC-addressed instruction-memory request/ack port.

---
 rtl/instruction_fetch_queue.sv | 105 ++++++++++
 tb/tb_instruction_fetch_queue.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_queue.sv
// Fetch unit: issues one PC-addressed memory request at a time and queues {instr, pc}
// in a prefetch FIFO whose head is offered to decode; a stalled head holds, redirect flushes.
module instruction_fetch_queue #(
  parameter int                     PC_WIDTH = 32,
  parameter int                     IWIDTH   = 32,
  parameter int                     QDEPTH   = 4,
  parameter logic [PC_WIDTH-1:0]    RESET_PC = '0,
  parameter logic [PC_WIDTH-1:0]    PC_STEP  = PC_WIDTH'(4)
) (
  input  logic                      f_clk,
  input  logic                      f_rst,
  input  logic                      f_i_ce,
  input  logic                      f_i_redirect,
  input  logic [PC_WIDTH-1:0]       f_i_redirect_pc,
  output logic                      f_o_req,
  output logic [PC_WIDTH-1:0]       f_o_addr,
  input  logic                      f_i_ack,
  input  logic [IWIDTH-1:0]         f_i_instr,
  output logic                      f_o_ce,
  output logic [IWIDTH-1:0]         f_o_instr,
  output logic [PC_WIDTH-1:0]       f_o_pc,
  input  logic                      f_i_stall,
  output logic [$clog2(QDEPTH):0]   f_o_count
);

  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(QDEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

  state_t              state;
  logic [PC_WIDTH-1:0] pc;
  logic [IWIDTH-1:0]   q_instr [QDEPTH];
  logic [PC_WIDTH-1:0] q_pc    [QDEPTH];
  logic [AW-1:0]       rd_ptr;
  logic [AW-1:0]       wr_ptr;
  logic [CW-1:0]       count;
  logic                push;
  logic                pop;
  logic                issue;

  // Issue only from IDLE, so the outstanding slot is already reflected in the count test.
  always_comb begin
    push  = (state == S_WAIT) && f_i_ack && !f_i_redirect;
    pop   = (count != '0) && !f_i_stall && !f_i_redirect;
    issue = (state == S_IDLE) && f_i_ce && !f_i_redirect && (count < DEPTH_C);
  end

  always_ff @(posedge f_clk) begin
    if (f_rst) begin
      state    <= S_IDLE;
      pc       <= RESET_PC;
      f_o_req  <= 1'b0;
      f_o_addr <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      f_o_req  <= issue;
      f_o_addr <= issue ? pc : '0;

      // An ack in DROP retires the stale request even if another redirect arrives.
      case (state)
        S_IDLE:  if (issue) state <= S_WAIT;
        S_WAIT:  if (f_i_ack) state <= S_IDLE;
                 else if (f_i_redirect) state <= S_DROP;
        S_DROP:  if (f_i_ack) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      if (f_i_redirect) begin
        pc     <= f_i_redirect_pc;
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + 1'b1;
          pc     <= pc + PC_STEP;
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // The fetch PC is unchanged while a request is outstanding, so it is the entry's PC.
  always_ff @(posedge f_clk) begin
    if (push) begin
      q_instr[wr_ptr] <= f_i_instr;
      q_pc[wr_ptr]    <= pc;
    end
  end

  assign f_o_count = count;
  assign f_o_ce    = (count != '0);
  assign f_o_instr = f_o_ce ? q_instr[rd_ptr] : '0;
  assign f_o_pc    = f_o_ce ? q_pc[rd_ptr] : '0;

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Bench for instruction_fetch_queue: memory responder, ordered scoreboard of fetched
// entries, a table of steady-state phases, and hand sequences for redirect and reset.
module tb_instruction_fetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        req;
  logic [31:0] addr;
  logic        ack = 1'b0;
  logic [31:0] instr_in = '0;
  logic        o_ce;
  logic [31:0] o_instr;
  logic [31:0] o_pc;
  logic        stall = 1'b0;
  logic [2:0]  count;

  instruction_fetch_queue dut (
    .f_clk(clk), .f_rst(rst), .f_i_ce(ce), .f_i_redirect(redirect),
    .f_i_redirect_pc(redirect_pc), .f_o_req(req), .f_o_addr(addr),
    .f_i_ack(ack), .f_i_instr(instr_in), .f_o_ce(o_ce), .f_o_instr(o_instr),
    .f_o_pc(o_pc), .f_i_stall(stall), .f_o_count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  typedef struct {
    logic        rst, ce, stall;
    int          cycles, reqs, cnt, maxc;
    logic [31:0] head;
  } vec_t;

  ent_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  bit          pend = 0;
  bit          pend_stale = 0;
  int          pend_wait = 0;
  logic [31:0] pend_addr = '0;
  logic [31:0] exp_pc = '0;
  int          ack_delay = 1;
  int          row_reqs = 0;
  int          row_max = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: capture pre-edge inputs/outputs, advance the model, check, drive memory.
  task automatic tick();
    logic        p_rst, p_redir, p_ack, p_pop, new_req;
    logic [31:0] p_rpc, p_pc, p_instr;
    ent_t        e;
    p_rst = rst; p_redir = redirect; p_ack = ack; p_rpc = redirect_pc;
    p_pop = o_ce && !stall; p_pc = o_pc; p_instr = o_instr;
    @(posedge clk);
    #1;
    if (p_rst) begin
      sb.delete();
      pend   = 0;
      exp_pc = 32'h0;
    end else begin
      if (p_pop && !p_redir) begin
        chk("pop_nonempty", (sb.size() != 0), 1);
        if (sb.size() != 0) begin
          chk("pop_pc", p_pc, sb[0].pc);
          chk("pop_instr", p_instr, sb[0].instr);
          void'(sb.pop_front());
        end
      end
      if (p_ack) begin
        if (!pend_stale && !p_redir) begin
          e.pc = pend_addr;
          e.instr = mem_word(pend_addr);
          sb.push_back(e);
          exp_pc = exp_pc + 32'd4;
        end
        pend = 0;
      end
      if (p_redir) begin
        sb.delete();
        exp_pc = p_rpc;
        pend_stale = 1;
      end
    end
    new_req = 0;
    if (req) begin
      row_reqs++;
      chk("one_outstanding", pend, 0);
      chk("req_addr", addr, exp_pc);
      pend = 1; pend_stale = 0; pend_addr = addr; pend_wait = ack_delay; new_req = 1;
    end
    chk("count", count, sb.size());
    chk("head_valid", o_ce, (sb.size() != 0));
    if (sb.size() == 0) begin
      chk("empty_pc", o_pc, 0);
      chk("empty_instr", o_instr, 0);
    end
    chk("no_overflow", ((sb.size() + int'(pend)) <= 4), 1);
    if (int'(count) > row_max) row_max = int'(count);
    ack = 1'b0;
    instr_in = $urandom;
    if (pend && !new_req) begin
      if (pend_wait > 1) pend_wait--;
      else begin
        ack = 1'b1;
        instr_in = mem_word(pend_addr);
      end
    end
  endtask

  vec_t tbl[7];

  initial begin
    // rst, ce, stall, cycles, reqs, count, max count, head pc at end
    tbl[0] = '{1'b1, 1'b0, 1'b0,  2, 0, 0, 0, 32'h0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 12, 4, 1, 1, 32'hC};
    tbl[2] = '{1'b0, 1'b0, 1'b0,  4, 0, 0, 0, 32'h0};
    tbl[3] = '{1'b1, 1'b0, 1'b0,  2, 0, 0, 0, 32'h0};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 16, 4, 4, 4, 32'h0};
    tbl[5] = '{1'b0, 1'b1, 1'b0,  5, 2, 0, 3, 32'h0};
    tbl[6] = '{1'b0, 1'b0, 1'b0,  6, 0, 0, 1, 32'h0};

    @(negedge clk);
    for (int r = 0; r < 7; r++) begin
      rst = tbl[r].rst; ce = tbl[r].ce; stall = tbl[r].stall; ack_delay = 1;
      row_reqs = 0; row_max = 0;
      repeat (tbl[r].cycles) tick();
      chk($sformatf("row%0d_reqs", r), row_reqs, tbl[r].reqs);
      chk($sformatf("row%0d_count", r), count, tbl[r].cnt);
      chk($sformatf("row%0d_max", r), row_max, tbl[r].maxc);
      chk($sformatf("row%0d_head", r), o_pc, tbl[r].head);
    end

    // Redirect while waiting; the late ack (2 cycles) must be discarded.
    ack_delay = 2; ce = 1'b1; stall = 1'b1;
    for (int i = 0; i < 60 && !(req && count >= 2); i++) tick();
    chk("t3_setup", (req && count >= 2), 1);
    redirect = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    chk("t3_flush_count", count, 0);
    for (int i = 0; i < 10 && !req; i++) tick();
    chk("t3_req_seen", req, 1);
    chk("t3_req_addr", addr, 32'h100);
    stall = 1'b0;
    for (int i = 0; i < 10 && !o_ce; i++) tick();
    chk("t3_head_pc", o_pc, 32'h100);
    chk("t3_head_instr", o_instr, mem_word(32'h100));

    // Redirect coinciding with an ack and a pop.
    ack_delay = 1; stall = 1'b1;
    for (int i = 0; i < 40 && !(ack && o_ce); i++) tick();
    chk("t4_setup", (ack && o_ce), 1);
    redirect = 1'b1; redirect_pc = 32'h200; stall = 1'b0;
    tick();
    redirect = 1'b0;
    chk("t4_flush_count", count, 0);
    for (int i = 0; i < 20 && !o_ce; i++) tick();
    chk("t4_head_pc", o_pc, 32'h200);
    chk("t4_head_instr", o_instr, mem_word(32'h200));

    // PC wrap at the top of the address space.
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    for (int i = 0; i < 40 && count != 2; i++) tick();
    chk("wrap_count", count, 2);
    chk("wrap_head_first", o_pc, 32'hFFFF_FFFC);
    stall = 1'b0;
    tick();
    stall = 1'b1;
    chk("wrap_head_second", o_pc, 32'h0);

    // Reset with three entries queued and a request outstanding.
    for (int i = 0; i < 40 && !(req && count == 3); i++) tick();
    chk("t6_setup", (req && count == 3), 1);
    rst = 1'b1;
    tick();
    chk("t6_req", req, 0);
    chk("t6_addr", addr, 0);
    chk("t6_ce", o_ce, 0);
    chk("t6_instr", o_instr, 0);
    chk("t6_pc", o_pc, 0);
    chk("t6_count", count, 0);
    rst = 1'b0; stall = 1'b0;
    for (int i = 0; i < 6 && !req; i++) tick();
    chk("t6_req_seen", req, 1);
    chk("t6_req_addr", addr, 32'h0);

    ce = 1'b0;
    repeat (10) tick();
    chk("drain_count", count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
